// File: rtl/ctrl_pkg.sv
// Shared constants for the control_seq_p sequencer: state codes, opcodes,
// ALU function codes and datapath select encodings.
package ctrl_pkg;

    localparam logic [2:0] S_FETCH     = 3'b000;
    localparam logic [2:0] S_DECODE    = 3'b001;
    localparam logic [2:0] S_EXECUTE   = 3'b010;
    localparam logic [2:0] S_MEMORY    = 3'b011;
    localparam logic [2:0] S_WRITEBACK = 3'b100;
    localparam logic [2:0] S_HALT      = 3'b101;
    localparam logic [2:0] S_IDLE      = 3'b110;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LDA  = 3'b001;
    localparam logic [2:0] OP_STA  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_LDIB = 3'b101;
    localparam logic [2:0] OP_JZ   = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    localparam logic PC_SRC_INC = 1'b0;
    localparam logic PC_SRC_JMP = 1'b1;
    localparam logic JMP_REL    = 1'b0;
    localparam logic ADDR_PC    = 1'b0;
    localparam logic ADDR_OFF   = 1'b1;
    localparam logic SRC_ALU    = 1'b0;
    localparam logic SRC_MEM    = 1'b1;
    localparam logic ALU_IN_REG = 1'b0;

    // States in which a memory request is outstanding and wait states accrue.
    function automatic logic is_wait_state(input logic [2:0] s);
        return (s == S_FETCH) || (s == S_MEMORY);
    endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Wait-state watchdog for control_seq_p. Counts consecutive cycles spent in a
// request state with mem_ready low; flags expiry on the MAX_WAIT-th such cycle
// and holds a sticky fault until reset. Only used with CTRL_WAIT_TIMEOUT_EN.
module ctrl_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic in_wait,
    input  logic mem_ready,
    output logic expire,
    output logic fault
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] cnt;

    // Expiry fires on the cycle the counter would step to MAX_WAIT.
    always_comb begin
        expire = in_wait && !mem_ready && (cnt == CNT_W'(MAX_WAIT - 1));
    end

    // Counter restarts whenever a request completes or the FSM leaves a request state.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (!in_wait || mem_ready) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Sticky fault flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault <= 1'b0;
        end else if (expire) begin
            fault <= 1'b1;
        end
    end

endmodule

// File: rtl/control_seq_p.sv
// control_seq_p: multi-cycle control sequencer for the small CPU. Owns the
// FSM state register and decodes state/instr/zf/mem_ready into datapath
// strobes, with a ready/request memory handshake.
// Optional: define CTRL_WAIT_TIMEOUT_EN to add a wait-state timeout that
// halts with a sticky fault after MAX_WAIT stalled cycles.
//
// state      | meaning
// -----------+-----------------------------------------------
// FETCH  000 | read instr at PC, load IR, PC+1 on mem_ready
// DECODE 001 | dispatch on opcode
// EXECUTE 010| ALU op, LDIB load of B, or JZ branch
// MEMORY 011 | data read/write at offset, wait for mem_ready
// WRITEBACK 100 | write A from ALU or memory
// HALT   101 | halted, run resumes (unless faulted)
// IDLE   110 | after reset, run starts
// 111        | illegal, recovers to IDLE
module control_seq_p
    import ctrl_pkg::*;
#(
    parameter int INSTR_W  = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr,
    input  logic               zf,
    input  logic               mem_ready,
    input  logic               run,
    output logic [2:0]         state,
    output logic               pc_we,
    output logic               pc_sel,
    output logic               pc_jmp_sel,
    output logic [INSTR_W-4:0] pc_offset,
    output logic               addr_sel,
    output logic [INSTR_W-4:0] addr_offset,
    output logic               mem_req,
    output logic               mem_sel,
    output logic               mem_we,
    output logic [2:0]         alu_opcode,
    output logic               alu_sel_a,
    output logic               alu_sel_b,
    output logic               alu_we,
    output logic               zf_we,
    output logic               ir_we,
    output logic               a_sel,
    output logic               a_we,
    output logic               b_sel,
    output logic               b_we,
    output logic               halt,
    output logic               fault
);

    localparam int OFF_W = INSTR_W - 3;

    logic [2:0]       next_state;
    logic [2:0]       opcode;
    logic [OFF_W-1:0] offset;
    logic             wait_expire;
    logic             fault_q;

    assign opcode = instr[INSTR_W-1 -: 3];
    assign offset = instr[OFF_W-1:0];

`ifdef CTRL_WAIT_TIMEOUT_EN
    ctrl_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .in_wait   (is_wait_state(state)),
        .mem_ready (mem_ready),
        .expire    (wait_expire),
        .fault     (fault_q)
    );
`else
    assign wait_expire = 1'b0;
    assign fault_q     = 1'b0;
`endif

    // fault is an output like any other and is masked while reset is high.
    assign fault = fault_q & ~reset;

    // State register; reset always wins over run and mem_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and strobe decode; everything stays 0 while reset is high.
    always_comb begin
        next_state  = state;
        pc_we       = 1'b0;
        pc_sel      = PC_SRC_INC;
        pc_jmp_sel  = JMP_REL;
        pc_offset   = '0;
        addr_sel    = ADDR_PC;
        addr_offset = '0;
        mem_req     = 1'b0;
        mem_sel     = 1'b0;
        mem_we      = 1'b0;
        alu_opcode  = ALU_ADD;
        alu_sel_a   = ALU_IN_REG;
        alu_sel_b   = ALU_IN_REG;
        alu_we      = 1'b0;
        zf_we       = 1'b0;
        ir_we       = 1'b0;
        a_sel       = SRC_ALU;
        a_we        = 1'b0;
        b_sel       = SRC_ALU;
        b_we        = 1'b0;
        halt        = 1'b0;

        if (!reset) begin
            case (state)
                S_IDLE: begin
                    if (run) next_state = S_FETCH;
                end

                S_FETCH: begin
                    mem_req  = 1'b1;
                    addr_sel = ADDR_PC;
                    if (mem_ready) begin
                        ir_we      = 1'b1;
                        pc_we      = 1'b1;
                        pc_sel     = PC_SRC_INC;
                        next_state = S_DECODE;
                    end else if (wait_expire) begin
                        next_state = S_HALT;
                    end
                end

                S_DECODE: begin
                    case (opcode)
                        OP_NOP:                   next_state = S_FETCH;
                        OP_LDA, OP_STA:           next_state = S_MEMORY;
                        OP_ADD, OP_SUB, OP_LDIB,
                        OP_JZ:                    next_state = S_EXECUTE;
                        default:                  next_state = S_HALT;
                    endcase
                end

                S_EXECUTE: begin
                    next_state = S_FETCH;
                    case (opcode)
                        OP_ADD, OP_SUB: begin
                            alu_opcode = (opcode == OP_SUB) ? ALU_SUB : ALU_ADD;
                            alu_sel_a  = ALU_IN_REG;
                            alu_sel_b  = ALU_IN_REG;
                            alu_we     = 1'b1;
                            zf_we      = 1'b1;
                            next_state = S_WRITEBACK;
                        end
                        OP_LDIB: begin
                            b_sel = SRC_MEM;
                            b_we  = 1'b1;
                        end
                        OP_JZ: begin
                            pc_offset = offset;
                            if (zf) begin
                                pc_we      = 1'b1;
                                pc_sel     = PC_SRC_JMP;
                                pc_jmp_sel = JMP_REL;
                            end
                        end
                        default: ;
                    endcase
                end

                S_MEMORY: begin
                    addr_sel    = ADDR_OFF;
                    addr_offset = offset;
                    mem_req     = 1'b1;
                    mem_sel     = 1'b1;
                    mem_we      = (opcode == OP_STA);
                    if (mem_ready) begin
                        next_state = (opcode == OP_LDA) ? S_WRITEBACK : S_FETCH;
                    end else if (wait_expire) begin
                        next_state = S_HALT;
                    end
                end

                S_WRITEBACK: begin
                    a_we       = 1'b1;
                    a_sel      = (opcode == OP_LDA) ? SRC_MEM : SRC_ALU;
                    next_state = S_FETCH;
                end

                S_HALT: begin
                    halt = 1'b1;
                    if (run && !fault_q) next_state = S_FETCH;
                end

                default: begin
                    next_state = S_IDLE;
                end
            endcase
        end
    end

endmodule
